// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered UART transmitter. Words enter a small FIFO through a valid/ready
// handshake and are serialised LSB-first as: start bit, DATA_WIDTH data bits,
// optional parity bit, one or two stop bits. Each bit lasts BAUD_DIV+1 cycles.
// While the FIFO holds data, frames are sent back-to-back with no idle gap.
// Framing options and the bit period are captured when a frame starts, so
// changing them mid-frame only affects the next frame.
//
// Ports:
//   CLK         clock; all state changes on the rising edge
//   RST         asynchronous active-high reset
//   P_DATA      word to transmit
//   DATA_VALID  P_DATA is valid
//   DATA_READY  FIFO can accept a word (count < FIFO_DEPTH)
//   PAR_EN      1 = append a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   STOP2       1 = two stop bits
//   BAUD_DIV    bit period is BAUD_DIV+1 cycles
//   TX_OUT      serial line, idles high (registered)
//   Busy        a frame is in progress (registered)
//   FIFO_COUNT  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          DATA_VALID,
    output logic                          DATA_READY,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    input  logic [DIV_WIDTH-1:0]          BAUD_DIV,
    output logic                          TX_OUT,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP1  = 3'd4;
    localparam logic [2:0] S_STOP2  = 3'd5;

    // FIFO storage and control
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  push;
    logic                  pop;

    // Transmit FSM and per-frame latched settings
    logic [2:0]            state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  par_en_lat_q, par_en_lat_d;
    logic                  stop2_lat_q, stop2_lat_d;
    logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic                  bit_end;
    logic                  final_stop;
    logic                  start_frame;

    assign rd_data    = mem_q[rd_ptr_q];
    assign DATA_READY = (count_q < DEPTH_C);
    assign FIFO_COUNT = count_q;
    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;

    assign bit_end     = (cnt_q == '0);
    // The final stop bit is STOP1 when one stop bit is latched, else STOP2.
    assign final_stop  = bit_end &&
                         (((state_q == S_STOP1) && !stop2_lat_q) || (state_q == S_STOP2));
    assign start_frame = ((state_q == S_IDLE) || final_stop) && (count_q != '0);

    assign push = DATA_VALID && DATA_READY;
    assign pop  = start_frame;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = P_DATA;
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        par_en_lat_d = par_en_lat_q;
        stop2_lat_d  = stop2_lat_q;
        div_lat_d    = div_lat_q;

        // Bit-period down-counter reloads at the end of every bit.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? div_lat_q : cnt_q - DIV_WIDTH'(1);
        end

        if (bit_end) begin
            case (state_q)
                S_START: begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = par_en_lat_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
                S_PARITY: state_d = S_STOP1;
                S_STOP1:  state_d = stop2_lat_q ? S_STOP2 : S_IDLE;
                S_STOP2:  state_d = S_IDLE;
                default:  state_d = state_q;
            endcase
        end

        // A new frame starts from IDLE or straight out of the final stop bit;
        // this overrides the IDLE transition above, giving back-to-back frames.
        if (start_frame) begin
            state_d      = S_START;
            shift_d      = rd_data;
            par_d        = (^rd_data) ^ PAR_TYP;
            par_en_lat_d = PAR_EN;
            stop2_lat_d  = STOP2;
            div_lat_d    = BAUD_DIV;
            cnt_d        = BAUD_DIV;
        end

        // Outputs are registered, so they are decoded from the next state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // Data-path registers carry no reset; they are always loaded before use.
    always_ff @(posedge CLK) begin
        mem_q        <= mem_d;
        shift_q      <= shift_d;
        par_q        <= par_d;
        par_en_lat_q <= par_en_lat_d;
        stop2_lat_q  <= stop2_lat_d;
        div_lat_q    <= div_lat_d;
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Directed testbench for uart_tx_buffered (DATA_WIDTH=8, FIFO_DEPTH=4,
// DIV_WIDTH=16). Expected serial patterns are written out by hand in
// transmit order (leftmost bit goes out first).
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  P_DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        STOP2;
    logic [15:0] BAUD_DIV;
    logic        TX_OUT;
    logic        Busy;
    logic [2:0]  FIFO_COUNT;

    int vectors     = 0;
    int miscompares = 0;

    // Per-negedge record of the line, plus an edge counter.
    logic rec_tx   [4096];
    logic rec_busy [4096];
    int   nidx = 0;
    int   cyc  = 0;

    uart_tx_buffered #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .DIV_WIDTH (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .BAUD_DIV  (BAUD_DIV),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy),
        .FIFO_COUNT(FIFO_COUNT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (nidx < 4096) begin
            rec_tx[nidx]   <= TX_OUT;
            rec_busy[nidx] <= Busy;
            nidx           <= nidx + 1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Single-cycle push; returns #1 after the accepting edge k.
    task automatic push_word(input logic [7:0] w);
        @(posedge CLK);
        #1 P_DATA = w;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
    endtask

    // Called #1 after push edge k. Checks the idle cycle before k+1, then
    // every cycle of the frame, then the idle cycle after it.
    task automatic check_frame(input string tag, input logic [15:0] seq,
                               input int n, input int div);
        @(negedge CLK);
        chk1({tag, "_pre_tx"}, TX_OUT, 1'b1);
        chk1({tag, "_pre_busy"}, Busy, 1'b0);
        chkn({tag, "_pre_count"}, 32'(FIFO_COUNT), 1);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c <= div; c++) begin
                @(negedge CLK);
                chk1($sformatf("%s_bit%0d_c%0d", tag, i, c), TX_OUT, seq[n-1-i]);
                chk1($sformatf("%s_busy%0d_c%0d", tag, i, c), Busy, 1'b1);
            end
        end
        @(negedge CLK);
        chk1({tag, "_post_tx"}, TX_OUT, 1'b1);
        chk1({tag, "_post_busy"}, Busy, 1'b0);
        chkn({tag, "_post_count"}, 32'(FIFO_COUNT), 0);
    endtask

    initial begin
        int          base;
        int          acc [1:6];
        logic        got;
        logic [7:0]  wv;
        logic        ebit;
        logic [15:0] s1;
        logic [15:0] s2;

        RST        = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;
        BAUD_DIV   = 16'd0;

        // Reset values
        #2;
        chk1("rst_tx", TX_OUT, 1'b1);
        chk1("rst_busy", Busy, 1'b0);
        chkn("rst_count", 32'(FIFO_COUNT), 0);
        chk1("rst_ready", DATA_READY, 1'b1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // 0xA5, even parity, one stop, one cycle per bit
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd0;
        push_word(8'hA5);
        check_frame("a5_even", 16'b0_10100101_0_1, 11, 0);

        // 0xA5, odd parity
        PAR_TYP = 1'b1;
        push_word(8'hA5);
        check_frame("a5_odd", 16'b0_10100101_1_1, 11, 0);

        // 0x3C, no parity, two stop bits, four cycles per bit
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; BAUD_DIV = 16'd3;
        push_word(8'h3C);
        check_frame("3c_slow", 16'b0_00111100_1_1, 11, 3);

        // FIFO full and back-to-back frames
        PAR_EN = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd0;
        base = 0;
        @(posedge CLK);
        #1;
        for (int w = 1; w <= 6; w++) begin
            P_DATA     = 8'(w);
            DATA_VALID = 1'b1;
            if (w == 6) begin
                @(negedge CLK);
                chk1("full_ready_low", DATA_READY, 1'b0);
                chkn("full_count", 32'(FIFO_COUNT), 4);
            end
            got = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge CLK);
                if (DATA_READY) begin
                    got = 1'b1;
                    break;
                end
            end
            chk1($sformatf("full_ready_w%0d", w), got, 1'b1);
            @(posedge CLK);
            #1 acc[w] = cyc;
            if (w == 1) base = nidx;
        end
        DATA_VALID = 1'b0;
        chkn("acc_w2", 32'(acc[2] - acc[1]), 1);
        chkn("acc_w3", 32'(acc[3] - acc[1]), 2);
        chkn("acc_w4", 32'(acc[4] - acc[1]), 3);
        chkn("acc_w5", 32'(acc[5] - acc[1]), 4);
        chkn("acc_w6", 32'(acc[6] - acc[1]), 12);
        repeat (60) @(negedge CLK);
        for (int f = 0; f < 6; f++) begin
            wv = 8'(f + 1);
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      ebit = 1'b0;
                else if (b == 9) ebit = 1'b1;
                else             ebit = wv[b-1];
                chk1($sformatf("b2b_f%0d_b%0d", f, b), rec_tx[base+1+10*f+b], ebit);
                chk1($sformatf("b2b_busy_f%0d_b%0d", f, b), rec_busy[base+1+10*f+b], 1'b1);
            end
        end
        chk1("b2b_end_tx", rec_tx[base+61], 1'b1);
        chk1("b2b_end_busy", rec_busy[base+61], 1'b0);

        // Configuration change mid-frame
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd1;
        @(posedge CLK);
        #1 P_DATA = 8'hA5;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 base = nidx;
        P_DATA = 8'h0F;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1 PAR_EN = 1'b0;
        BAUD_DIV = 16'd0;
        repeat (40) @(negedge CLK);
        s1 = 16'b0_10100101_0_1;
        s2 = 16'b0_11110000_1;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < 2; c++) begin
                chk1($sformatf("cfg_f1_b%0d_c%0d", i, c), rec_tx[base+1+2*i+c], s1[10-i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("cfg_f2_b%0d", i), rec_tx[base+23+i], s2[9-i]);
        end
        chk1("cfg_end_tx", rec_tx[base+33], 1'b1);
        chk1("cfg_end_busy", rec_busy[base+33], 1'b0);

        // Reset mid-frame with two words buffered
        PAR_EN = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd3;
        @(posedge CLK);
        #1 P_DATA = 8'h11;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 P_DATA = 8'h22;
        @(posedge CLK);
        #1 P_DATA = 8'h33;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chkn("mid_count", 32'(FIFO_COUNT), 2);
        chk1("mid_busy", Busy, 1'b1);
        chk1("mid_data_bit0", TX_OUT, 1'b1);
        RST = 1'b1;
        #1;
        chk1("arst_tx", TX_OUT, 1'b1);
        chk1("arst_busy", Busy, 1'b0);
        chkn("arst_count", 32'(FIFO_COUNT), 0);
        chk1("arst_ready", DATA_READY, 1'b1);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            chk1($sformatf("post_rst_tx%0d", i), TX_OUT, 1'b1);
            chk1($sformatf("post_rst_busy%0d", i), Busy, 1'b0);
        end

        // Recovery after reset
        BAUD_DIV = 16'd0;
        push_word(8'h5A);
        check_frame("5a_recover", 16'b0_01011010_1, 10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered UART transmitter for the system's TX path. It accepts parallel words through a valid/ready handshake into an internal FIFO, and serialises them LSB-first onto TX_OUT. Frames are start, data, optional parity, and one or two stop bits, at a programmable bit period. Consecutive frames go out back-to-back, with no idle gap, while the FIFO holds data.

## Interface
- DATA_WIDTH, default 8: data bits per frame and width of P_DATA; ≥ 5.
- FIFO_DEPTH, default 4: FIFO entries; power of 2, ≥ 2.
- DIV_WIDTH, default 16: width of BAUD_DIV.

- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  word to transmit.
- DATA_VALID  in  1  P_DATA is valid.
- DATA_READY  out  1  the FIFO can accept a word; equals (count < FIFO_DEPTH).
- PAR_EN  in  1  1 = add a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  1 = two stop bits.
- BAUD_DIV  in  DIV_WIDTH  bit period is BAUD_DIV+1 cycles.
- TX_OUT  out  1  serial line; idles high.
- Busy  out  1  a frame is in progress (state ≠ IDLE).
- FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** a word is written on an edge where DATA_VALID && DATA_READY. When the FIFO is full, the word is not written and the source holds it.
- **No bypass:** every word passes through the FIFO.
- **Pop:** happens on an edge where the FSM is starting a frame. That is, in IDLE, or in the last cycle of the final stop bit, with count > 0.
- **Simultaneous push and pop:** count is unchanged.
- **Frame start:** the FSM latches, for the whole frame:
  - the popped word into a shift register;
  - PAR_EN, PAR_TYP, STOP2 and BAUD_DIV;
  - parity: the XOR of the word, inverted when PAR_TYP = 1.
- **Configuration changes mid-frame** have no effect until the next frame starts.
- **FSM states:**
  - IDLE: TX_OUT = 1.
  - START: TX_OUT = 0.
  - DATA: TX_OUT = shift-register LSB, shifted right once per bit; DATA_WIDTH bits.
  - PARITY: TX_OUT = latched parity. Entered only if PAR_EN was latched.
  - STOP1: TX_OUT = 1.
  - STOP2: TX_OUT = 1. Entered only if STOP2 was latched.
- **Bit timing:** a down-counter is loaded with the latched BAUD_DIV when a bit starts. A bit ends when the counter is 0, so each bit lasts BAUD_DIV+1 cycles. A bit counter tracks the data bits.
- **Transitions (at the end of each bit):**
  - START → DATA.
  - DATA → DATA until the last data bit, then → PARITY if parity is enabled, else → STOP1.
  - PARITY → STOP1.
  - STOP1 → STOP2 if two stop bits are latched. Otherwise STOP1 is the final stop bit.
  - From the final stop bit: → START with a pop if count > 0, else → IDLE.
- **Frame length:** (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × (BAUD_DIV + 1) cycles.

## Timing
- **Reset values** (applied asynchronously while RST = 1):
  - TX_OUT = 1, Busy = 0, FIFO_COUNT = 0, DATA_READY = 1;
  - state = IDLE; FIFO pointers cleared.
- **Reset mid-frame:** TX_OUT goes high immediately, the frame is truncated and buffered words are discarded. After RST falls, the block stays idle until a new push.
- **Registered outputs:** TX_OUT and Busy are registered. DATA_READY and FIFO_COUNT come from the count register.
- **Latency:** for a word pushed at edge k into an empty FIFO with the FSM idle:
  - pop at edge k+1;
  - TX_OUT = 0 and Busy = 1 from edge k+1.
- **Back-to-back frames:** the next start bit follows the last stop-bit cycle directly, with zero idle cycles.
- **Busy** falls on the edge that ends the final stop bit, when the FIFO is empty.
- **BAUD_DIV = 0:** one cycle per bit.

## Test plan
- **Single frame, even parity:** DATA_WIDTH=8, BAUD_DIV=0, PAR_EN=1, PAR_TYP=0, STOP2=0; push 0xA5. Required response:
  - TX_OUT from edge k+1: 0, 1,0,1,0,0,1,0,1, 0, 1 (11 cycles);
  - Busy high exactly 11 cycles.
- **Odd parity:** same setup with PAR_TYP=1 → the parity bit is 1; all other bits unchanged.
- **Slow bit period, no parity, two stop bits:** BAUD_DIV=3, PAR_EN=0, STOP2=1; push 0x3C. Required response:
  - 11 bits of 4 cycles each (44 cycles);
  - data bits 0,0,1,1,1,1,0,0, then four-cycle high pairs for the two stop bits.
- **FIFO full and back-to-back:** FIFO_DEPTH=4, BAUD_DIV=0; hold DATA_VALID for words 0x01–0x06. Required response:
  - words 1–5 accepted on edges 0–4; DATA_READY low after edge 4;
  - word 6 accepted only after a later pop;
  - six contiguous frames with no idle cycle between them.
- **Configuration change mid-frame:** toggle PAR_EN 1→0 and change BAUD_DIV during a frame. Required response: the current frame keeps its parity bit and bit period; the next frame uses the new settings.
- **Reset mid-frame:** assert RST during the DATA state with 2 words buffered. Required response:
  - TX_OUT = 1, Busy = 0, FIFO_COUNT = 0 immediately;
  - no frame is sent after release until a new push.
